// File: rtl/multicycle_datapath.sv
// multicycle_datapath: multi-cycle RV32I-subset core (fetch/decode/exec/mem/wb) sharing one req/ack memory port.
// Optional MULTICYCLE_PERF_CNT_EN enables the cycle_cnt / instret_cnt performance counters.
module multicycle_datapath #(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic [XLEN-1:0] pc,
    output logic            retire,
    output logic            halted,
    output logic [1:0]      fault,
    input  logic [4:0]      dbg_raddr,
    output logic [XLEN-1:0] dbg_rdata,
    output logic [31:0]     cycle_cnt,
    output logic [31:0]     instret_cnt
);

    // state  | meaning
    // FETCH  | request instruction at pc, latch into ir on ack
    // DECODE | read rs1/rs2 into a/b, build immediate, legality check
    // EXEC   | alu result, effective address or branch/jump target
    // MEM    | load or store through the shared port
    // WB     | register write, pc update, retire pulse
    // HALT   | stopped after a fault, held until reset
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STOR = 7'b0100011;
    localparam logic [6:0] OP_BRAN = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [1:0] FAULT_NONE     = 2'd0;
    localparam logic [1:0] FAULT_ILLEGAL  = 2'd1;
    localparam logic [1:0] FAULT_MISALIGN = 2'd2;

    localparam int         RIDX_W      = $clog2(NREGS);
    // Index bits that must be zero for the configured register count.
    localparam logic [4:0] IDX_HI_MASK = 5'(~((32'd1 << RIDX_W) - 32'd1));

    state_t state, state_nx;

    logic [31:0]     ir;
    logic [XLEN-1:0] pc_q, a_q, b_q, imm_q, alu_q, mdr_q;
    logic            taken_q;
    logic [1:0]      fault_q;
    logic [XLEN-1:0] regs [NREGS];

    logic [6:0] opcode, funct7;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] funct3;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];

    logic is_rtype, is_addi, is_lw, is_sw, is_beq, is_jal;
    logic uses_rd, uses_rs1, uses_rs2, idx_bad, legal;

    assign is_rtype = (opcode == OP_R) &&
                      (((funct7 == 7'h00) && ((funct3 == 3'b000) || (funct3 == 3'b010) ||
                                              (funct3 == 3'b100) || (funct3 == 3'b110) ||
                                              (funct3 == 3'b111))) ||
                       ((funct7 == 7'h20) && (funct3 == 3'b000)));
    assign is_addi  = (opcode == OP_IMM)  && (funct3 == 3'b000);
    assign is_lw    = (opcode == OP_LOAD) && (funct3 == 3'b010);
    assign is_sw    = (opcode == OP_STOR) && (funct3 == 3'b010);
    assign is_beq   = (opcode == OP_BRAN) && (funct3 == 3'b000);
    assign is_jal   = (opcode == OP_JAL);

    assign uses_rd  = is_rtype | is_addi | is_lw | is_jal;
    assign uses_rs1 = is_rtype | is_addi | is_lw | is_sw | is_beq;
    assign uses_rs2 = is_rtype | is_sw | is_beq;
    assign idx_bad  = (uses_rd  && ((rd  & IDX_HI_MASK) != 5'd0)) ||
                      (uses_rs1 && ((rs1 & IDX_HI_MASK) != 5'd0)) ||
                      (uses_rs2 && ((rs2 & IDX_HI_MASK) != 5'd0));
    assign legal    = (is_rtype | is_addi | is_lw | is_sw | is_beq | is_jal) && !idx_bad;

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_dec;

    assign imm_i = {{(XLEN-12){ir[31]}}, ir[31:20]};
    assign imm_s = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_j = {{(XLEN-21){ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    always_comb begin
        imm_dec = imm_i;
        if (is_sw)       imm_dec = imm_s;
        else if (is_beq) imm_dec = imm_b;
        else if (is_jal) imm_dec = imm_j;
    end

    logic [XLEN-1:0] alu_res, pc_plus4;
    logic            slt_res, br_eq, exec_misalign;

    assign pc_plus4 = pc_q + XLEN'(4);
    assign slt_res  = $signed(a_q) < $signed(b_q);
    assign br_eq    = (a_q == b_q);

    always_comb begin
        alu_res = a_q + imm_q;
        if (is_rtype) begin
            case (funct3)
                3'b000:  alu_res = funct7[5] ? (a_q - b_q) : (a_q + b_q);
                3'b010:  alu_res = {{(XLEN-1){1'b0}}, slt_res};
                3'b100:  alu_res = a_q ^ b_q;
                3'b110:  alu_res = a_q | b_q;
                3'b111:  alu_res = a_q & b_q;
                default: alu_res = a_q + b_q;
            endcase
        end else if (is_beq || is_jal) begin
            alu_res = pc_q + imm_q;
        end
    end

    // A not-taken branch never faults on its target.
    always_comb begin
        exec_misalign = 1'b0;
        if (is_lw || is_sw)
            exec_misalign = (alu_res[1:0] != 2'b00);
        else if (is_jal || (is_beq && br_eq))
            exec_misalign = alu_res[1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FETCH;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            FETCH:   if (mem_ack) state_nx = DECODE;
            DECODE:  state_nx = legal ? EXEC : HALT;
            EXEC: begin
                if (exec_misalign)        state_nx = HALT;
                else if (is_lw || is_sw)  state_nx = MEM;
                else                      state_nx = WB;
            end
            MEM:     if (mem_ack) state_nx = WB;
            WB:      state_nx = FETCH;
            HALT:    state_nx = HALT;
            default: state_nx = HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= RESET_PC;
            ir      <= '0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
            taken_q <= 1'b0;
            fault_q <= FAULT_NONE;
        end else begin
            case (state)
                FETCH: if (mem_ack) ir <= mem_rdata[31:0];
                DECODE: begin
                    a_q   <= regs[rs1[RIDX_W-1:0]];
                    b_q   <= regs[rs2[RIDX_W-1:0]];
                    imm_q <= imm_dec;
                    if (!legal) fault_q <= FAULT_ILLEGAL;
                end
                EXEC: begin
                    alu_q   <= alu_res;
                    taken_q <= br_eq;
                    if (exec_misalign) fault_q <= FAULT_MISALIGN;
                end
                MEM: if (mem_ack) mdr_q <= mem_rdata;
                WB:  pc_q <= (is_jal || (is_beq && taken_q)) ? alu_q : pc_plus4;
                default: ;
            endcase
        end
    end

    logic            rf_we;
    logic [XLEN-1:0] rf_wdata;

    assign rf_we    = (state == WB) && (rd != 5'd0) && uses_rd;
    assign rf_wdata = is_lw ? mdr_q : (is_jal ? pc_plus4 : alu_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (rf_we) begin
            regs[rd[RIDX_W-1:0]] <= rf_wdata;
        end
    end

    assign dbg_rdata = ((dbg_raddr == 5'd0) || ((dbg_raddr & IDX_HI_MASK) != 5'd0)) ?
                       '0 : regs[dbg_raddr[RIDX_W-1:0]];

    // Gating with rst drops an outstanding request the moment reset asserts.
    assign mem_req   = rst && ((state == FETCH) || (state == MEM));
    assign mem_we    = (state == MEM) && is_sw;
    assign mem_addr  = (state == MEM) ? alu_q : pc_q;
    assign mem_wdata = ((state == MEM) && is_sw) ? b_q : '0;

    assign pc     = pc_q;
    assign retire = (state == WB);
    assign halted = (state == HALT);
    assign fault  = fault_q;

`ifdef MULTICYCLE_PERF_CNT_EN
    logic [31:0] cycle_q, instret_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if (state != HALT) cycle_q   <= cycle_q + 32'd1;
            if (retire)        instret_q <= instret_q + 32'd1;
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

// File: doc/multicycle_datapath.md
Name: multicycle_datapath

Overview:
- Parametrised multi-cycle RV32I-subset core: datapath plus its own control FSM in one block.
- Executes one instruction over several clock cycles: fetch, decode, execute, memory, writeback.
- A single shared memory port with a req/ack handshake serves both instruction fetch and data access, so memory latency can vary.
- Sits where the single-cycle datapath sat; the instruction and data memories move outside the block, behind the handshake port.

Parameters:
- XLEN, 32, datapath/register width (32 or 64; instructions always 32 bit)
- NREGS, 32, register count (16 or 32); rd/rs index bits at or above log2(NREGS) → illegal instruction
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- mem_req  out  1  memory request, held until accepted
- mem_we  out  1  1 = store, 0 = load/fetch
- mem_addr  out  XLEN  byte address, word aligned
- mem_wdata  out  XLEN  store data (rs2)
- mem_rdata  in  XLEN  read data, valid in the cycle mem_ack=1
- mem_ack  in  1  request accepted/completed this cycle
- pc  out  XLEN  current PC
- retire  out  1  one-cycle pulse per completed instruction
- halted  out  1  core stopped (sticky until reset)
- fault  out  2  0 none, 1 illegal opcode, 2 misaligned address
- dbg_raddr  in  5  register-file debug read index
- dbg_rdata  out  XLEN  combinational register read; 0 for index 0 or index >= NREGS
- cycle_cnt  out  32  see Optional Feature
- instret_cnt  out  32  see Optional Feature

Behaviour:
Reset (rst=0, async):
- State FETCH; pc=RESET_PC; all registers 0; outputs mem_req, mem_we, retire, halted, fault all 0.
- Reset while a memory request is outstanding drops mem_req immediately; the transaction is abandoned.

Handshake:
- mem_req rises with mem_addr, mem_we and mem_wdata valid, all held stable until mem_ack is sampled high.
- mem_req is 0 in the cycle after an ack; no back-to-back requests.
- mem_ack while mem_req=0 is ignored.

FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: req with addr=pc, we=0. On ack, IR<=mem_rdata → DECODE.
- DECODE: read rs1/rs2 into A/B; sign-extend immediate (I/S/B/J). Unsupported opcode or out-of-range register index → fault=1, HALT.
- EXEC: compute ALU result.
  - R-type: add, sub, and, or, xor, slt (signed).
  - I-type: addi.
  - lw/sw: address = rs1+imm. If addr[1:0]!=0 → fault=2, HALT.
  - beq: compare A==B.
  - jal: target = pc+imm.
  - Branch/jump target misaligned (bit1 set) → fault=2, HALT.
  - Next state: MEM for lw/sw, otherwise WB.
- MEM: req with addr=ALU result; we=1 for sw. On ack, MDR<=mem_rdata → WB.
- WB:
  - Write rd with ALU result / MDR / pc+4 (jal). Writes to x0 are discarded.
  - pc <= taken branch or jal ? target : pc+4.
  - retire=1 for this cycle only → FETCH.
- HALT: absorbing until reset. pc frozen at the faulting instruction, no requests, retire=0.
- Arithmetic wraps modulo 2^XLEN; pc+4 wraps. For XLEN=64, lw/sw transfer XLEN bits (no extension).

Latency:
- Minimum CPI with ack in the first request cycle: 4 cycles for ALU/branch/jal, 5 cycles for lw/sw.
- Each wait cycle on ack adds one cycle.

Optional Feature:
- Macro: MULTICYCLE_PERF_CNT_EN.
- Defined:
  - cycle_cnt increments every clock while not halted.
  - instret_cnt increments on each retire pulse.
  - Both reset to 0 and wrap at 2^32.
- Undefined: both ports are driven constant 0 and no counter flops are inferred.

Test Plan:
- Memory with zero-wait ack; program addi x1,x0,5; addi x2,x0,7; add x3,x1,x2 → dbg read x3=12; retire pulses at cycles 4, 8, 12 after reset release.
- Memory holding mem_ack low 3 cycles per request, sw x3,8(x0) then lw x4,8(x0) → write address 8 with data 12 seen once; x4=12; mem_addr, mem_we and mem_wdata stable throughout the wait.
- beq x1,x1,+8 with x1=5 → pc jumps by 8; jal x5,-4 at pc=0x10 → x5=0x14, pc=0x0C; addi x0,x0,9 → x0 reads 0.
- Opcode 0x7F at pc=0x20 → fault=1, halted=1, pc stays 0x20, no further mem_req; lw with rs1+imm=6 → fault=2.
- rst asserted mid-MEM with mem_req=1 → mem_req=0 same cycle; after release the first request is a fetch at RESET_PC.
- With MULTICYCLE_PERF_CNT_EN, run the 3-instruction program then halt → instret_cnt=3 and cycle_cnt frozen once halted; without the macro both counters read 0.
